// File: rtl/mix_column_engine.sv
// rtl/mix_column_engine.sv - AES MixColumns / InvMixColumns engine, 1/2/4 columns per clock
module mix_column_engine #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int SUPPORT_INV    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  // Only 1, 2 or 4 columns per cycle divide the 4-column state evenly.
  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("mix_column_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [2:0] CPC_STEP = 3'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state;
  logic [1:0]     col_idx;
  logic [127:0]   blk_state;
  logic           blk_inv;
  logic           eff_inv;
  logic           last_step;
  logic [127:0]   next_out;

  logic [1:0]     lane_col [COLS_PER_CYCLE];
  logic [31:0]    lane_res [COLS_PER_CYCLE];

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant as an XOR of 1x, 2x, 4x and 8x terms.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] a2;
    logic [7:0] a4;
    logic [7:0] a8;
    a2 = xtime(a);
    a4 = xtime(a2);
    a8 = xtime(a4);
    gf_mul = (k[0] ? a  : 8'h00) ^
             (k[1] ? a2 : 8'h00) ^
             (k[2] ? a4 : 8'h00) ^
             (k[3] ? a8 : 8'h00);
  endfunction

  // One column through the circulant matrix; row r uses the base row rotated right by r.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a    [4];
    logic [7:0] b    [4];
    logic [3:0] coef [4];
    logic [1:0] sel;
    if (inv) begin
      coef[0] = 4'he; coef[1] = 4'hb; coef[2] = 4'hd; coef[3] = 4'h9;
    end else begin
      coef[0] = 4'h2; coef[1] = 4'h3; coef[2] = 4'h1; coef[3] = 4'h1;
    end
    for (int r = 0; r < 4; r++) begin
      a[r] = col[31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      b[r] = 8'h00;
      for (int c = 0; c < 4; c++) begin
        sel  = 2'(c - r);
        b[r] = b[r] ^ gf_mul(a[c], coef[sel]);
      end
    end
    mix_col = {b[0], b[1], b[2], b[3]};
  endfunction

  // Column c sits at [127-32c -: 32].
  function automatic logic [6:0] col_msb(input logic [1:0] c);
    col_msb = 7'd127 - {c, 5'b00000};
  endfunction

  assign eff_inv   = (SUPPORT_INV != 0) ? in_inv : 1'b0;
  assign last_step = (({1'b0, col_idx} + CPC_STEP) == 3'd4);
  assign in_ready  = (state == ST_IDLE) && !rst;

  // One transform lane per column handled in a cycle.
  generate
    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
      assign lane_col[j] = col_idx + 2'(j);
      assign lane_res[j] = mix_col(blk_state[col_msb(lane_col[j]) -: 32], blk_inv);
    end
  endgenerate

  // Merge this cycle's lane results into their own byte lanes; other columns keep their value.
  always_comb begin
    next_out = out_state;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      next_out[col_msb(lane_col[j]) -: 32] = lane_res[j];
    end
  end

  // Control FSM with captured block, column counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      col_idx   <= 2'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_state <= 128'd0;
      blk_state <= 128'd0;
      blk_inv   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            blk_state <= in_state;
            blk_inv   <= eff_inv;
            col_idx   <= 2'd0;
            busy      <= 1'b1;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          out_state <= next_out;
          col_idx   <= col_idx + CPC_STEP[1:0];
          if (last_step) begin
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_column_engine.sv
// tb/tb_mix_column_engine.sv - randomized self-checking bench against a matrix-level reference
module tb_mix_column_engine;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        in_valid_v;
  logic [127:0]      in_state;
  logic              in_inv;
  logic              out_ready;
  wire  [3:0]        in_ready_v;
  wire  [3:0]        out_valid_v;
  wire  [3:0]        busy_v;
  wire  [3:0][127:0] out_state_v;

  int n_tests = 0;
  int n_fail  = 0;
  int lat_of [4] = '{4, 2, 1, 4};

  always #5 clk = ~clk;

  mix_column_engine #(.COLS_PER_CYCLE(1), .SUPPORT_INV(1)) u_cpc1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .out_state(out_state_v[0]), .busy(busy_v[0]));

  mix_column_engine #(.COLS_PER_CYCLE(2), .SUPPORT_INV(1)) u_cpc2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .out_state(out_state_v[1]), .busy(busy_v[1]));

  mix_column_engine #(.COLS_PER_CYCLE(4), .SUPPORT_INV(1)) u_cpc4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .out_state(out_state_v[2]), .busy(busy_v[2]));

  mix_column_engine #(.COLS_PER_CYCLE(1), .SUPPORT_INV(0)) u_noinv (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(out_valid_v[3]),
    .out_ready(out_ready), .out_state(out_state_v[3]), .busy(busy_v[3]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Carry-less product then reduction by the AES polynomial 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (((k >> i) & 1) != 0) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] st, input bit inv);
    int fwd [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    int bwd [4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};
    logic [127:0] res;
    logic [7:0]   acc;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++)
          acc = acc ^ gmul(st[127-32*c-8*i -: 8], inv ? bwd[r][i] : fwd[r][i]);
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic start_block(input int k, input logic [127:0] st, input bit inv, input string tag);
    in_state      = st;
    in_inv        = inv;
    in_valid_v[k] = 1'b1;
    check({tag, "_in_ready"}, 128'(in_ready_v[k]), 128'd1);
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
    check({tag, "_busy"}, 128'(busy_v[k]), 128'd1);
  endtask

  task automatic wait_done(input int k, input int lat, input string tag);
    int cycles;
    cycles = 0;
    while (!out_valid_v[k] && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, "_latency"}, 128'(cycles), 128'(lat));
  endtask

  task automatic release_out(input int k, input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, 128'(out_valid_v[k]), 128'd0);
    check({tag, "_rel_ready"}, 128'(in_ready_v[k]), 128'd1);
  endtask

  task automatic full_block(input int k, input logic [127:0] st, input bit inv,
                            input logic [127:0] exp, input string tag);
    start_block(k, st, inv, tag);
    wait_done(k, lat_of[k], tag);
    check({tag, "_out"}, out_state_v[k], exp);
    release_out(k, tag);
  endtask

  initial begin
    logic [127:0] v_in;
    logic [127:0] v_out;
    logic [127:0] v_dp;
    logic [127:0] v_dpo;
    logic [127:0] prev;
    logic [127:0] st;
    logic [127:0] exp;
    bit           inv;
    bit           seen;

    v_in  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    v_out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    v_dp  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    v_dpo = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    rst = 1'b1; in_valid_v = 4'b0000; out_ready = 1'b0; in_state = '0; in_inv = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready_v), 128'd0);
    check("rst_out_valid", 128'(out_valid_v), 128'd0);
    check("rst_busy", 128'(busy_v), 128'd0);
    for (int k = 0; k < 4; k++) check("rst_out_state", out_state_v[k], 128'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready_v), 128'hf);

    // Directed vectors.
    check("ref_sanity_fwd", ref_mix(v_in, 1'b0), v_out);
    full_block(0, v_in, 1'b0, v_out, "fwd_cpc1");
    full_block(1, v_dp, 1'b0, v_dpo, "fwd_cpc2");
    full_block(2, v_out, 1'b1, v_in, "inv_cpc4");
    full_block(3, v_in, 1'b1, v_out, "noinv_fwd");

    // out_ready while idle does nothing.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_ready_valid", 128'(out_valid_v), 128'd0);
    check("idle_ready_in_ready", 128'(in_ready_v), 128'hf);

    // Column-by-column update on CPC=1: unwritten columns keep the previous result.
    prev = out_state_v[0];
    st   = {$urandom, $urandom, $urandom, $urandom};
    exp  = ref_mix(st, 1'b0);
    start_block(0, st, 1'b0, "partial");
    check("partial_none", out_state_v[0], prev);
    @(posedge clk); #1;
    check("partial_col0", out_state_v[0], {exp[127:96], prev[95:0]});
    @(posedge clk); #1;
    check("partial_col1", out_state_v[0], {exp[127:64], prev[63:0]});
    wait_done(0, 2, "partial");
    check("partial_out", out_state_v[0], exp);
    release_out(0, "partial");

    // Backpressure in DONE with a competing in_valid.
    st  = {$urandom, $urandom, $urandom, $urandom};
    exp = ref_mix(st, 1'b1);
    start_block(0, st, 1'b1, "bp");
    wait_done(0, 4, "bp");
    for (int i = 0; i < 10; i++) begin
      in_valid_v[0] = 1'b1;
      in_state      = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check("bp_stable", out_state_v[0], exp);
      check("bp_in_ready", 128'(in_ready_v[0]), 128'd0);
      check("bp_valid", 128'(out_valid_v[0]), 128'd1);
    end
    in_valid_v[0] = 1'b0;
    release_out(0, "bp");

    // Reset in the second BUSY cycle aborts the block.
    st = {$urandom, $urandom, $urandom, $urandom};
    start_block(0, st, 1'b0, "abort");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_valid", 128'(out_valid_v[0]), 128'd0);
    check("abort_state", out_state_v[0], 128'd0);
    check("abort_busy", 128'(busy_v[0]), 128'd0);
    check("abort_in_ready", 128'(in_ready_v[0]), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid_v[0]) seen = 1'b1;
    end
    check("abort_no_valid", 128'(seen), 128'd0);
    full_block(0, v_in, 1'b0, v_out, "after_abort");

    // Randomized blocks on every configuration.
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 4; k++) begin
        st  = {$urandom, $urandom, $urandom, $urandom};
        inv = 1'($urandom_range(0, 1));
        exp = ref_mix(st, (k == 3) ? 1'b0 : inv);
        full_block(k, st, inv, exp, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
